// File: rtl/axi_pkg.sv
// Shared AXI definitions: arbiter FSM states, response codes and a one-hot helper.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: rr names the requester preferred on a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] grant
);

  // A lone requester always wins; a tie goes to the requester rr points at.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = axi_pkg::onehot2(rr);
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates two AXI read masters onto one slave, one whole burst per grant,
// with a per-handshake stall timeout that aborts the burst.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*ADDR_WIDTH-1:0] req_araddr,
  input  logic [15:0]             req_arlen,
  input  logic [1:0]              req_arvalid,
  output logic [1:0]              req_arready,
  output logic [DATA_WIDTH-1:0]   req_rdata,
  output logic [1:0]              req_rvalid,
  input  logic [1:0]              req_rready,
  output logic [1:0]              req_rlast,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_rvalid,
  input  logic                    m_rlast,
  output logic                    m_rready,
  output logic [1:0]              grant,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic                  rr_q, rr_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;

  logic [1:0] sel;
  logic       owner;
  logic       beat;

  rr_arbiter2 u_rr (
    .req   (req_arvalid),
    .rr    (rr_q),
    .grant (sel)
  );

  assign owner = grant_q[1];
  assign beat  = m_rvalid && req_rready[owner];

  // State register: every flop clears immediately when rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      grant_q <= 2'b00;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state: grant in IDLE, wait for address accept, stream beats, abort on stall.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req_arvalid) begin
          state_d = ADDR;
          grant_d = sel;
          addr_d  = sel[1] ? req_araddr[ADDR_WIDTH +: ADDR_WIDTH] : req_araddr[0 +: ADDR_WIDTH];
          len_d   = sel[1] ? req_arlen[8 +: 8] : req_arlen[0 +: 8];
        end
      end
      ADDR: begin
        if (m_arready) begin
          state_d = DATA;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = IDLE;
          grant_d = 2'b00;
          rr_d    = ~owner;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (beat) begin
          cnt_d = '0;
          if (m_rlast) begin
            state_d = IDLE;
            grant_d = 2'b00;
            rr_d    = ~owner;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = IDLE;
          grant_d = 2'b00;
          rr_d    = ~owner;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: accept only in IDLE, drive the slave in ADDR, route the data channel in DATA.
  always_comb begin
    req_arready = 2'b00;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    req_rvalid  = 2'b00;
    req_rlast   = 2'b00;
    req_rdata   = '0;
    m_araddr    = addr_q;
    m_arlen     = len_q;
    grant       = grant_q;
    timeout_err = tmo_q;
    case (state_q)
      IDLE: req_arready = sel;
      ADDR: m_arvalid = 1'b1;
      DATA: begin
        m_rready   = req_rready[owner];
        req_rvalid = m_rvalid ? grant_q : 2'b00;
        req_rlast  = (m_rvalid && m_rlast) ? grant_q : 2'b00;
        req_rdata  = m_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized scoreboard bench for axi_read_arbiter with directed corner cases.
module tb_axi_read_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          owner;
  } ar_exp_t;

  typedef struct {
    logic [31:0] data;
    int          owner;
    bit          last;
  } beat_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   req_araddr;
  logic [15:0]   req_arlen;
  logic [1:0]    req_arvalid, req_arready, req_rvalid, req_rready, req_rlast;
  logic [DW-1:0] req_rdata;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic          m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    grant;
  logic          timeout_err;

  int vectors = 0;
  int miscompares = 0;

  burst_t    req_q0[$], req_q1[$], slv_q[$];
  ar_exp_t   exp_ar_q[$];
  beat_exp_t exp_beat_q[$];
  int        grant_log[$];
  int        beats_seen[2];

  bit fast_mode, ar_block;
  int hold_rr0;

  axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rvalid(req_rvalid),
    .req_rready(req_rready), .req_rlast(req_rlast),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .grant(grant), .timeout_err(timeout_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] data_fn(input logic [31:0] addr, input int b);
    return addr ^ (32'h9E37_0000 + 32'(b) * 32'h0101);
  endfunction

  function automatic logic [1:0] onehot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester and slave drivers: sample handshakes at negedge, update inputs after posedge.
  bit [1:0] s_ar_hs;
  bit       s_m_ar_hs, s_m_r_hs, s_m_last, s_busy;
  int       drv_stall = 0;
  int       beat_idx = 0;
  bit       go;
  always begin
    @(negedge clk);
    s_ar_hs   = req_arvalid & req_arready;
    s_m_ar_hs = m_arvalid & m_arready;
    s_m_r_hs  = m_rvalid & m_rready;
    s_m_last  = m_rlast;
    s_busy    = (grant != 2'b00);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      slv_q.delete();
      beat_idx    = 0;
      drv_stall   = 0;
      m_arready   = 1'b0;
      m_rvalid    = 1'b0;
      m_rlast     = 1'b0;
      m_rdata     = '0;
      req_arvalid = 2'b00;
      req_rready  = 2'b00;
    end else begin
      if (s_busy && !(s_m_ar_hs || s_m_r_hs)) drv_stall++;
      else drv_stall = 0;
      go = (drv_stall >= 6);
      if (s_ar_hs[0] && req_q0.size() != 0) void'(req_q0.pop_front());
      if (s_ar_hs[1] && req_q1.size() != 0) void'(req_q1.pop_front());
      req_arvalid[0] = (req_q0.size() != 0);
      req_arvalid[1] = (req_q1.size() != 0);
      req_araddr[31:0]  = req_arvalid[0] ? req_q0[0].addr : 32'h0;
      req_arlen[7:0]    = req_arvalid[0] ? req_q0[0].len  : 8'h0;
      req_araddr[63:32] = req_arvalid[1] ? req_q1[0].addr : 32'h0;
      req_arlen[15:8]   = req_arvalid[1] ? req_q1[0].len  : 8'h0;
      if (s_m_ar_hs) slv_q.push_back({m_araddr, m_arlen});
      if (s_m_r_hs && slv_q.size() != 0) begin
        if (s_m_last) begin
          void'(slv_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      m_arready = !ar_block && (fast_mode || go || ($urandom_range(0, 1) == 1));
      if (!(m_rvalid && !s_m_r_hs)) begin
        if (slv_q.size() != 0 && (fast_mode || go || $urandom_range(0, 4) != 0)) begin
          m_rvalid = 1'b1;
          m_rdata  = data_fn(slv_q[0].addr, beat_idx);
          m_rlast  = (beat_idx == int'(slv_q[0].len));
        end else begin
          m_rvalid = 1'b0;
          m_rlast  = 1'b0;
        end
      end
      if (hold_rr0 > 0) begin
        req_rready = 2'b10;
        hold_rr0--;
      end else if (fast_mode || go) begin
        req_rready = 2'b11;
      end else begin
        req_rready[0] = ($urandom_range(0, 3) != 0);
        req_rready[1] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Scoreboard monitor: a behavioural model of who should own the channel and what it should carry.
  int        last_winner = 1;
  int        mdl_stall = 0;
  bit        tmo_due = 0, tmo_in_addr = 0, addr_due = 0;
  int        w, o;
  ar_exp_t   ea;
  beat_exp_t eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ar_q.delete();
      exp_beat_q.delete();
      last_winner = 1;
      mdl_stall   = 0;
      tmo_due     = 0;
      addr_due    = 0;
    end else begin
      check_output("timeout_err", timeout_err, tmo_due);
      if (tmo_due) begin
        if (tmo_in_addr) begin
          if (exp_ar_q.size() != 0) void'(exp_ar_q.pop_front());
        end else begin
          exp_beat_q.delete();
        end
      end
      tmo_due = 0;
      if (addr_due) check_output("m_arvalid_after_accept", m_arvalid, 1);
      addr_due = 0;
      if (grant == 2'b00) begin
        mdl_stall = 0;
        check_output("idle_m_arvalid", m_arvalid, 0);
        check_output("idle_m_rready", m_rready, 0);
        check_output("idle_req_rvalid", req_rvalid, 0);
        if (req_arvalid != 2'b00) begin
          w = (req_arvalid == 2'b11) ? 1 - last_winner : (req_arvalid[1] ? 1 : 0);
          check_output("arready_winner", req_arready, onehot(w));
          ea.addr  = req_araddr[w*32 +: 32];
          ea.len   = req_arlen[w*8 +: 8];
          ea.owner = w;
          exp_ar_q.push_back(ea);
          last_winner = w;
          grant_log.push_back(w);
          addr_due = 1;
        end else begin
          check_output("arready_none", req_arready, 0);
        end
      end else begin
        check_output("grant_onehot", $onehot(grant), 1);
        check_output("busy_arready", req_arready, 0);
        if (m_arvalid) begin
          tmo_in_addr = 1;
          check_output("addr_m_rready", m_rready, 0);
          check_output("addr_req_rvalid", req_rvalid, 0);
          if (exp_ar_q.size() == 0) begin
            check_output("addr_expected_burst", 0, 1);
          end else begin
            ea = exp_ar_q[0];
            check_output("m_araddr", m_araddr, ea.addr);
            check_output("m_arlen", m_arlen, ea.len);
            check_output("addr_grant", grant, onehot(ea.owner));
            if (m_arready) begin
              void'(exp_ar_q.pop_front());
              for (int b = 0; b <= int'(ea.len); b++) begin
                eb.data  = data_fn(ea.addr, b);
                eb.owner = ea.owner;
                eb.last  = (b == int'(ea.len));
                exp_beat_q.push_back(eb);
              end
              mdl_stall = 0;
            end else begin
              mdl_stall++;
            end
          end
        end else begin
          tmo_in_addr = 0;
          if (exp_beat_q.size() == 0) begin
            check_output("data_expected_beat", 0, 1);
          end else begin
            eb = exp_beat_q[0];
            o  = eb.owner;
            check_output("data_grant", grant, onehot(o));
            check_output("m_rready_route", m_rready, req_rready[o]);
            check_output("req_rvalid_route", req_rvalid, m_rvalid ? onehot(o) : 2'b00);
            check_output("req_rlast_route", req_rlast, (m_rvalid && m_rlast) ? onehot(o) : 2'b00);
            if (m_rvalid && m_rready) begin
              check_output("req_rdata", req_rdata, eb.data);
              check_output("req_rlast_beat", req_rlast[o], eb.last);
              void'(exp_beat_q.pop_front());
              beats_seen[o]++;
              mdl_stall = 0;
            end else begin
              mdl_stall++;
            end
          end
        end
        if (mdl_stall == TMO) begin
          tmo_due   = 1;
          mdl_stall = 0;
        end
      end
    end
  end

  // Asynchronous reset pulse mid-cycle, checking that outputs clear at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("rst_grant", grant, 0);
    check_output("rst_req_arready", req_arready, 0);
    check_output("rst_req_rvalid", req_rvalid, 0);
    check_output("rst_req_rlast", req_rlast, 0);
    check_output("rst_m_arvalid", m_arvalid, 0);
    check_output("rst_m_rready", m_rready, 0);
    check_output("rst_timeout_err", timeout_err, 0);
    check_output("rst_m_araddr", m_araddr, 0);
    check_output("rst_m_arlen", m_arlen, 0);
    req_q0.delete();
    req_q1.delete();
    hold_rr0 = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      done = (req_q0.size() == 0) && (req_q1.size() == 0) && (req_arvalid == 2'b00) &&
             (grant == 2'b00) && (exp_ar_q.size() == 0) && (exp_beat_q.size() == 0);
    end
    check_output({tag, "_drain_done"}, done, 1);
  endtask

  task automatic wait_beats(input int target, input int base);
    int n = 0;
    while ((beats_seen[0] - base) < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("wait_beats_reached", ((beats_seen[0] - base) >= target), 1);
  endtask

  task automatic apply_stimulus(input int n_bursts);
    burst_t b;
    int     who;
    for (int i = 0; i < n_bursts; i++) begin
      @(negedge clk);
      #1;
      who = $urandom_range(0, 2);
      if (who != 1) begin
        b.addr = $urandom;
        b.len  = 8'($urandom_range(0, 7));
        req_q0.push_back(b);
      end
      if (who != 0) begin
        b.addr = $urandom;
        b.len  = 8'($urandom_range(0, 7));
        req_q1.push_back(b);
      end
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
  endtask

  // Safety net so the run can never hang.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  int b0, b1, low_cnt, addr_cycles, tmo_pulses, n;
  initial begin
    rst_n       = 1'b0;
    req_araddr  = '0;
    req_arlen   = '0;
    req_arvalid = 2'b00;
    req_rready  = 2'b00;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    m_rdata     = '0;
    fast_mode   = 1;
    ar_block    = 0;
    hold_rr0    = 0;
    beats_seen[0] = 0;
    beats_seen[1] = 0;
    do_reset();

    // Single burst from requester 0.
    grant_log.delete();
    b0 = beats_seen[0];
    b1 = beats_seen[1];
    @(negedge clk); #1;
    req_q0.push_back({32'h10, 8'd4});
    wait_drain(200, "single");
    check_output("single_grant_count", grant_log.size(), 1);
    if (grant_log.size() == 1) check_output("single_grant_owner", grant_log[0], 0);
    check_output("single_beats_req0", beats_seen[0] - b0, 5);
    check_output("single_beats_req1", beats_seen[1] - b1, 0);

    // Both requesting from reset: strict alternation starting with requester 0.
    do_reset();
    grant_log.delete();
    fast_mode = 0;
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_q0.push_back({32'h1000 + 32'(i) * 32'h40, 8'(i + 1)});
      req_q1.push_back({32'h2000 + 32'(i) * 32'h40, 8'(3 - i)});
    end
    wait_drain(3000, "alternate");
    check_output("alternate_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      check_output("alternate_grant_order", grant_log[i], i % 2);

    // Requester 0 withholds rready for three cycles mid-burst.
    fast_mode = 1;
    b0 = beats_seen[0];
    @(negedge clk); #1;
    req_q0.push_back({32'h80, 8'd7});
    wait_beats(2, b0);
    hold_rr0 = 3;
    low_cnt  = 0;
    n        = 0;
    while (!(grant == 2'b00 && exp_beat_q.size() == 0 && req_q0.size() == 0) && n < 200) begin
      @(negedge clk); #1;
      n++;
      if (grant == 2'b01 && !m_arvalid && !req_rready[0] && !m_rready) low_cnt++;
    end
    check_output("rready_hold_low_cycles", low_cnt, 3);
    check_output("rready_hold_beats", beats_seen[0] - b0, 8);

    // Randomized traffic with random slave and requester back-pressure.
    fast_mode = 0;
    apply_stimulus(40);
    wait_drain(20000, "random");

    // Address-phase timeout on requester 0 after requester 1 last held the channel.
    fast_mode = 1;
    @(negedge clk); #1;
    req_q1.push_back({32'h500, 8'd0});
    wait_drain(200, "pre_timeout");
    ar_block    = 1;
    addr_cycles = 0;
    tmo_pulses  = 0;
    @(negedge clk); #1;
    req_q0.push_back({32'h600, 8'd2});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (m_arvalid) addr_cycles++;
      if (timeout_err) tmo_pulses++;
    end
    check_output("timeout_addr_cycles", addr_cycles, TMO);
    check_output("timeout_pulses", tmo_pulses, 1);
    check_output("timeout_idle_grant", grant, 0);
    ar_block = 0;
    grant_log.delete();
    req_q0.push_back({32'h700, 8'd1});
    req_q1.push_back({32'h800, 8'd1});
    wait_drain(500, "post_timeout");
    check_output("post_timeout_count", grant_log.size(), 2);
    if (grant_log.size() >= 1) check_output("post_timeout_first", grant_log[0], 1);

    // Reset in the middle of a data burst, then a tie must go to requester 0.
    b0 = beats_seen[0];
    @(negedge clk); #1;
    req_q0.push_back({32'h200, 8'd7});
    wait_beats(2, b0);
    check_output("mid_burst_grant", grant, 2'b01);
    do_reset();
    grant_log.delete();
    @(negedge clk); #1;
    req_q0.push_back({32'h300, 8'd1});
    req_q1.push_back({32'h400, 8'd1});
    wait_drain(500, "after_reset");
    check_output("after_reset_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_output("after_reset_first", grant_log[0], 0);
      check_output("after_reset_second", grant_log[1], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
